// File: rtl/arith_arbiter.sv
// arith_arbiter: two requesters share one N-bit add/sub datapath through a round-robin grant
// into a single-entry registered result stage.
package alu_defs;
    localparam logic ARITH_ADD = 1'b0;
    localparam logic ARITH_SUB = 1'b1;
endpackage

module arith_arbiter
    import alu_defs::*;
#(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic         req0_op_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    input  logic         req1_op_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [N-1:0] res_o,
    output logic         res_overflow_o,
    output logic         res_cout_o,
    output logic         res_id_o
);
    logic         rr;
    logic         slot_free;
    logic         grant;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic [N:0]   r;
    logic         ovf;

    // rr names the requester that wins when both are valid
    assign slot_free    = !res_valid_o | res_ready_i;
    assign req0_ready_o = !rst_i & slot_free & req0_valid_i & (!req1_valid_i | !rr);
    assign req1_ready_o = !rst_i & slot_free & req1_valid_i & (!req0_valid_i | rr);
    assign grant        = req0_ready_o | req1_ready_o;

    always_comb begin
        a   = req1_ready_o ? req1_a_i  : req0_a_i;
        b   = req1_ready_o ? req1_b_i  : req0_b_i;
        op  = req1_ready_o ? req1_op_i : req0_op_i;
        r   = (op == ARITH_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        ovf = (op == ARITH_SUB) ? ((a[N-1] != b[N-1]) & (r[N-1] == b[N-1]))
                                : ((a[N-1] == b[N-1]) & (r[N-1] != b[N-1]));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr             <= 1'b0;
            res_valid_o    <= 1'b0;
            res_o          <= '0;
            res_overflow_o <= 1'b0;
            res_cout_o     <= 1'b0;
            res_id_o       <= 1'b0;
        end else if (grant) begin
            rr             <= req0_ready_o;
            res_valid_o    <= 1'b1;
            res_o          <= r[N-1:0];
            res_overflow_o <= ovf;
            res_cout_o     <= r[N];
            res_id_o       <= req1_ready_o;
        end else if (res_ready_i) begin
            res_valid_o    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arith_arbiter.sv
// tb_arith_arbiter: directed vectors with hand-computed results for arith_arbiter (N=4).
module tb_arith_arbiter;
    import alu_defs::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       rdy0, rdy1, res_valid, res_ready, res_ovf, res_cout, res_id;
    logic [3:0] res;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    arith_arbiter #(.N(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_a_i(a0), .req0_b_i(b0), .req0_op_i(op0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_a_i(a1), .req1_b_i(b1), .req1_op_i(op1),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res),
        .res_overflow_o(res_ovf), .res_cout_o(res_cout), .res_id_o(res_id)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rdy(input string tag, input logic e0, input logic e1);
        check({tag, " ready0"}, {7'd0, rdy0}, {7'd0, e0});
        check({tag, " ready1"}, {7'd0, rdy1}, {7'd0, e1});
    endtask

    task automatic check_res(input string tag, input logic ev, input logic [3:0] er,
                             input logic eo, input logic ec, input logic ei);
        check({tag, " valid"}, {7'd0, res_valid}, {7'd0, ev});
        check({tag, " res"}, {4'd0, res}, {4'd0, er});
        check({tag, " ovf"}, {7'd0, res_ovf}, {7'd0, eo});
        check({tag, " cout"}, {7'd0, res_cout}, {7'd0, ec});
        check({tag, " id"}, {7'd0, res_id}, {7'd0, ei});
    endtask

    task automatic req0(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b);
        v0 = v; op0 = op; a0 = a; b0 = b;
    endtask

    task automatic req1(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b);
        v1 = v; op1 = op; a1 = a; b1 = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        res_ready = 1'b1;
        req0(1, ARITH_ADD, 4'b0111, 4'b0001);
        req1(1, ARITH_ADD, 4'b1111, 4'b0001);
        @(negedge clk); #1;
        check_rdy("reset", 0, 0);
        check_res("reset", 0, 4'b0000, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        req1(0, ARITH_ADD, 4'b0000, 4'b0000);
        #1 check_rdy("add0", 1, 0);
        step();
        check_res("add0 7+1", 1, 4'b1000, 1, 0, 0);

        @(negedge clk);
        req0(0, ARITH_ADD, 4'b0000, 4'b0000);
        req1(1, ARITH_ADD, 4'b1111, 4'b0001);
        #1 check_rdy("add1", 0, 1);
        step();
        check_res("add1 15+1", 1, 4'b0000, 0, 1, 1);

        @(negedge clk);
        req1(1, ARITH_SUB, 4'b0010, 4'b0011);
        step();
        check_res("sub1 2-3", 1, 4'b1111, 0, 1, 1);

        @(negedge clk);
        req1(0, ARITH_ADD, 4'b0000, 4'b0000);
        req0(1, ARITH_SUB, 4'b1000, 4'b0001);
        step();
        check_res("sub0 8-1", 1, 4'b0111, 1, 0, 0);

        // rr now favours requester 1; both valid alternates 1,0,1,0
        @(negedge clk);
        req0(1, ARITH_ADD, 4'b0011, 4'b0010);
        req1(1, ARITH_SUB, 4'b0101, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            #1 check_rdy($sformatf("alt%0d", i), i[0], !i[0]);
            step();
            if (i[0]) check_res($sformatf("alt%0d", i), 1, 4'b0101, 0, 0, 0);
            else      check_res($sformatf("alt%0d", i), 1, 4'b0010, 0, 0, 1);
            @(negedge clk);
        end

        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_rdy($sformatf("stall%0d", i), 0, 0);
            step();
            check_res($sformatf("stall%0d", i), 1, 4'b0101, 0, 0, 0);
            @(negedge clk);
        end

        res_ready = 1'b1;
        #1 check_rdy("drain+refill", 0, 1);
        step();
        check_res("drain+refill", 1, 4'b0010, 0, 0, 1);

        @(negedge clk);
        req0(0, ARITH_ADD, 4'b0000, 4'b0000);
        req1(0, ARITH_ADD, 4'b0000, 4'b0000);
        #1 check_rdy("idle", 0, 0);
        step();
        check_res("drain only", 0, 4'b0010, 0, 0, 1);

        @(negedge clk);
        req0(1, ARITH_ADD, 4'b0111, 4'b0001);
        step();
        check_res("pre-reset", 1, 4'b1000, 1, 0, 0);

        @(negedge clk);
        req0(1, ARITH_ADD, 4'b0011, 4'b0010);
        req1(1, ARITH_SUB, 4'b0101, 4'b0011);
        rst = 1'b1;
        #1 check_res("async reset", 0, 4'b0000, 0, 0, 0);
        check_rdy("in reset", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_rdy("after reset", 1, 0);
        step();
        check_res("after reset", 1, 4'b0101, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous and active-high.
REQ-004 req0_valid_i  input  1  requester 0 holds a valid operation.
REQ-005 req0_ready_o  output  1  requester 0 operation accepted this cycle (grant).
REQ-006 req0_a_i, req0_b_i  input  N each  requester 0 operands.
REQ-007 req0_op_i  input  1  requester 0 opcode: ARITH_ADD or ARITH_SUB encoding from alu_defs.
REQ-008 req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_op_i  same as REQ-004..007, for requester 1.
REQ-009 res_valid_o  output  1  result register holds an undelivered result.
REQ-010 res_ready_i  input  1  consumer takes the result this cycle.
REQ-011 res_o  output  N  registered result, low N bits.
REQ-012 res_overflow_o  output  1  registered signed-overflow flag.
REQ-013 res_cout_o  output  1  registered bit N of the (N+1)-bit raw result.
REQ-014 res_id_o  output  1  index of the requester that owns the result.

Function
REQ-015 Block SHALL share one N-bit add/sub datapath between two requesters, with a single-entry registered result stage.
REQ-016 Transfer on a port SHALL occur only when valid and ready are both high in the same cycle.
REQ-017 Slot free: slot_free = !res_valid_o | res_ready_i (drain and refill in the same cycle allowed).
REQ-018 At most one of req0_ready_o / req1_ready_o SHALL be high per cycle, and only when slot_free and that requester's valid is high.
REQ-019 Only one requester valid and slot_free: that requester SHALL be granted.
REQ-020 Both valid and slot_free: grant SHALL go to the requester named by a round-robin pointer rr.
REQ-021 After every grant, rr SHALL point to the non-granted requester; without a grant, rr SHALL hold.
REQ-022 Ready outputs SHALL be combinational from valids, rr and slot_free; they SHALL NOT depend on operand values.
REQ-023 On a grant, the result register SHALL load the granted operands' result, flags and id; res_valid_o SHALL rise the next cycle (latency 1).
REQ-024 Result computed on zero-extended operands to N+1 bits: ADD r = a + b; SUB r = a - b (mod 2^(N+1)).
REQ-025 res_o SHALL be r[N-1:0]; res_cout_o SHALL be r[N] (ADD: carry out; SUB: 1 when a < b unsigned).
REQ-026 ADD overflow SHALL be (a[N-1] == b[N-1]) & (r[N-1] != b[N-1]).
REQ-027 SUB overflow SHALL be (a[N-1] != b[N-1]) & (r[N-1] == b[N-1]).
REQ-028 res_valid_o high and res_ready_i low: all res_* outputs SHALL hold stable and no grant SHALL occur.
REQ-029 res_ready_i high with no grant: res_valid_o SHALL fall next cycle; res_o, flags and id keep their last values.
REQ-030 Requester dropping valid before a grant SHALL be permitted, with no side effect on rr.

Reset
REQ-031 While rst_i is high: res_valid_o = 0, res_o = 0, res_overflow_o = 0, res_cout_o = 0, res_id_o = 0, rr = requester 0.
REQ-032 Reset asserted mid-operation SHALL discard any held result immediately (asynchronous).
REQ-033 Ready outputs SHALL be 0 while rst_i is high.
REQ-034 First grant after reset release SHALL go to requester 0 if both requesters are valid.

Verification (N=4)
REQ-035 req0 ADD a=0111 b=0001, res_ready_i=1 -> next cycle res_valid_o=1, res_o=1000, overflow=1, cout=0, id=0.
REQ-036 req1 ADD a=1111 b=0001 -> res_o=0000, cout=1, overflow=0, id=1; separately, SUB a=0010 b=0011 -> res_o=1111, cout=1, overflow=0.
REQ-037 SUB a=1000 b=0001 -> res_o=0111, overflow=1, cout=0.
REQ-038 Both valid continuously, res_ready_i=1 -> grants alternate 0,1,0,1 on consecutive cycles; one result per cycle, with res_id_o matching.
REQ-039 res_ready_i=0 for 3 cycles with both valid -> no ready asserted, res_* stable; res_ready_i=1 -> drain and new grant in the same cycle.
REQ-040 rst_i pulsed while res_valid_o=1 -> res_valid_o=0 immediately, no edge needed; next arbitration with both valid grants requester 0.
